// File: rtl/rc4_pkg.sv
// Shared RC4 constants and the PRGA state encoding.
package rc4_pkg;
  localparam int BYTE_W  = 8;
  localparam int S_DEPTH = 256;
  localparam int CHAR_LO = 97;
  localparam int CHAR_HI = 122;
  localparam logic [BYTE_W-1:0] SPACE = 8'h20;

  typedef enum logic [3:0] {
    IDLE,
    FETCH_SI, WAIT_SI, LATCH_SI,
    FETCH_SJ, WAIT_SJ, LATCH_SJ,
    WRITE_SI, WRITE_SJ,
    FETCH_F,  WAIT_F,  XOR_OUT,
    DONE
  } prga_state_t;
endpackage

// File: rtl/prga_byte_checker.sv
// Combinational plaintext filter: accepts CHAR_LO..CHAR_HI and optionally space.
module prga_byte_checker
  import rc4_pkg::*;
#(
  parameter int CHAR_LO     = rc4_pkg::CHAR_LO,
  parameter int CHAR_HI     = rc4_pkg::CHAR_HI,
  parameter bit ALLOW_SPACE = 1'b1
) (
  input  logic [BYTE_W-1:0] byte_in,
  output logic              accept
);
  always_comb begin
    accept = (int'(byte_in) >= CHAR_LO) && (int'(byte_in) <= CHAR_HI);
    if (ALLOW_SPACE && (byte_in == SPACE)) accept = 1'b1;
  end
endmodule

// File: rtl/prga_decrypt_fsm.sv
// RC4 PRGA + XOR decrypt over a 2-cycle-latency S memory, aborting on the first
// unprintable plaintext byte so the key search can move on quickly.
module prga_decrypt_fsm
  import rc4_pkg::*;
#(
  parameter int MSG_LEN     = 32,
  parameter int CHAR_LO     = rc4_pkg::CHAR_LO,
  parameter int CHAR_HI     = rc4_pkg::CHAR_HI,
  parameter bit ALLOW_SPACE = 1'b1
) (
  input  logic                       CLOCK_50,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [MSG_LEN*BYTE_W-1:0]  encrypted_data,
  input  logic [BYTE_W-1:0]          s_data_in,
  output logic [BYTE_W-1:0]          s_address_out,
  output logic [BYTE_W-1:0]          s_data_out,
  output logic                       s_write_enable_out,
  output logic [$clog2(MSG_LEN)-1:0] dec_address_out,
  output logic [BYTE_W-1:0]          dec_data_out,
  output logic                       dec_write_enable_out,
  output logic                       busy,
  output logic                       done,
  output logic                       key_valid
);
  localparam int K_W   = $clog2(MSG_LEN);
  localparam int IDX_W = $clog2(S_DEPTH);

  prga_state_t       state_q, state_d;
  logic [IDX_W-1:0]  i_q, i_d, j_q, j_d;
  logic [BYTE_W-1:0] si_q, si_d, sj_q, sj_d;
  logic [K_W-1:0]    k_q, k_d;
  logic              key_valid_q, key_valid_d;

  logic [BYTE_W-1:0] enc_byte, plain_byte;
  logic              byte_ok;

  assign enc_byte   = encrypted_data[int'(k_q)*BYTE_W +: BYTE_W];
  assign plain_byte = s_data_in ^ enc_byte;

  prga_byte_checker #(
    .CHAR_LO     (CHAR_LO),
    .CHAR_HI     (CHAR_HI),
    .ALLOW_SPACE (ALLOW_SPACE)
  ) u_checker (
    .byte_in (plain_byte),
    .accept  (byte_ok)
  );

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      si_q        <= '0;
      sj_q        <= '0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      si_q        <= si_d;
      sj_q        <= sj_d;
      key_valid_q <= key_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    si_d        = si_q;
    sj_d        = sj_q;
    key_valid_d = key_valid_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          i_d         = IDX_W'(1);
          j_d         = '0;
          k_d         = '0;
          key_valid_d = 1'b0;
          state_d     = FETCH_SI;
        end
      end
      FETCH_SI: state_d = WAIT_SI;
      WAIT_SI:  state_d = LATCH_SI;
      LATCH_SI: begin
        si_d    = s_data_in;
        j_d     = j_q + s_data_in;
        state_d = FETCH_SJ;
      end
      FETCH_SJ: state_d = WAIT_SJ;
      WAIT_SJ:  state_d = LATCH_SJ;
      LATCH_SJ: begin
        sj_d    = s_data_in;
        state_d = WRITE_SI;
      end
      WRITE_SI: state_d = WRITE_SJ;
      WRITE_SJ: state_d = FETCH_F;
      FETCH_F:  state_d = WAIT_F;
      WAIT_F:   state_d = XOR_OUT;
      XOR_OUT: begin
        if (!byte_ok) begin
          key_valid_d = 1'b0;
          state_d     = DONE;
        end else if (k_q == K_W'(MSG_LEN - 1)) begin
          key_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          k_d     = k_q + K_W'(1);
          i_d     = i_q + IDX_W'(1);
          state_d = FETCH_SI;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory-side strobes are pure decodes of the state so they drop with reset.
  always_comb begin
    s_address_out        = '0;
    s_data_out           = '0;
    s_write_enable_out   = 1'b0;
    dec_address_out      = '0;
    dec_data_out         = '0;
    dec_write_enable_out = 1'b0;
    case (state_q)
      FETCH_SI, WAIT_SI: s_address_out = i_q;
      FETCH_SJ, WAIT_SJ: s_address_out = j_q;
      WRITE_SI: begin
        s_address_out      = i_q;
        s_data_out         = sj_q;
        s_write_enable_out = 1'b1;
      end
      WRITE_SJ: begin
        s_address_out      = j_q;
        s_data_out         = si_q;
        s_write_enable_out = 1'b1;
      end
      FETCH_F, WAIT_F: s_address_out = si_q + sj_q;
      XOR_OUT: begin
        dec_address_out      = k_q;
        dec_data_out         = plain_byte;
        dec_write_enable_out = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy      = (state_q != IDLE) && (state_q != DONE);
  assign done      = (state_q == DONE);
  assign key_valid = key_valid_q;
endmodule

// File: tb/tb_prga_decrypt_fsm.sv
// Bench for prga_decrypt_fsm: 2-cycle S RAM model, write logger and an RC4 reference model.
module tb_prga_decrypt_fsm;
  localparam int MSG_LEN = 32;
  localparam int K_W     = $clog2(MSG_LEN);

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic                   start;
  logic [MSG_LEN*8-1:0]   encrypted_data;
  logic [7:0]             s_data_in, s_address_out, s_data_out;
  logic                   s_write_enable_out;
  logic [K_W-1:0]         dec_address_out;
  logic [7:0]             dec_data_out;
  logic                   dec_write_enable_out, busy, done, key_valid;

  prga_decrypt_fsm #(.MSG_LEN(MSG_LEN)) dut (
    .CLOCK_50             (clk),
    .reset_n              (reset_n),
    .start                (start),
    .encrypted_data       (encrypted_data),
    .s_data_in            (s_data_in),
    .s_address_out        (s_address_out),
    .s_data_out           (s_data_out),
    .s_write_enable_out   (s_write_enable_out),
    .dec_address_out      (dec_address_out),
    .dec_data_out         (dec_data_out),
    .dec_write_enable_out (dec_write_enable_out),
    .busy                 (busy),
    .done                 (done),
    .key_valid            (key_valid)
  );

  always #5 clk = ~clk;

  // S RAM with registered address and registered q, plus plaintext-write logger
  logic [7:0] smem [256];
  logic [7:0] s_init [256];
  logic [7:0] s_addr_r, s_q;
  logic       load_s;
  int         cyc = 0;
  int         wa_q[$], wd_q[$], wc_q[$];

  assign s_data_in = s_q;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    s_addr_r <= s_address_out;
    s_q      <= smem[s_addr_r];
    if (load_s) begin
      for (int n = 0; n < 256; n++) smem[n] <= s_init[n];
    end else if (s_write_enable_out) begin
      smem[s_address_out] <= s_data_out;
    end
    if (dec_write_enable_out) begin
      wa_q.push_back(int'(dec_address_out));
      wd_q.push_back(int'(dec_data_out));
      wc_q.push_back(cyc + 1);
    end
  end

  logic [33:0] outs;
  assign outs = {s_address_out, s_data_out, s_write_enable_out, dec_address_out,
                 dec_data_out, dec_write_enable_out, busy, done, key_valid};

  int n_err = 0;
  int n_checks = 0;
  int e0, wbase, last_d, last_n;

  logic [7:0] m_s [256];
  logic [7:0] enc_b [MSG_LEN];
  logic [7:0] plain_b [MSG_LEN];
  logic [7:0] exp_d[$];
  bit         exp_kv;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit is_ok(input logic [7:0] b);
    return ((b >= 8'd97) && (b <= 8'd122)) || (b == 8'd32);
  endfunction

  // Keystream for an all-printable message, used to build ciphertext from plaintext
  task automatic make_enc();
    logic [7:0] t [256];
    logic [7:0] tmp;
    int i = 0, j = 0;
    t = m_s;
    for (int k = 0; k < MSG_LEN; k++) begin
      i = (i + 1) % 256;
      j = (j + int'(t[i])) % 256;
      tmp = t[i]; t[i] = t[j]; t[j] = tmp;
      enc_b[k] = t[(int'(t[i]) + int'(t[j])) % 256] ^ plain_b[k];
    end
    for (int k = 0; k < MSG_LEN; k++) encrypted_data[k*8 +: 8] = enc_b[k];
  endtask

  // Reference decrypt with early abort; leaves m_s as the expected final S
  task automatic model_run();
    logic [7:0] tmp, p;
    int i = 0, j = 0;
    exp_d.delete();
    exp_kv = 1'b0;
    for (int k = 0; k < MSG_LEN; k++) begin
      i = (i + 1) % 256;
      j = (j + int'(m_s[i])) % 256;
      tmp = m_s[i]; m_s[i] = m_s[j]; m_s[j] = tmp;
      p = m_s[(int'(m_s[i]) + int'(m_s[j])) % 256] ^ enc_b[k];
      exp_d.push_back(p);
      if (!is_ok(p)) break;
      if (k == MSG_LEN - 1) exp_kv = 1'b1;
    end
  endtask

  task automatic load_mem();
    @(negedge clk) load_s = 1'b1;
    @(negedge clk) load_s = 1'b0;
    m_s = s_init;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    wbase = wa_q.size();
    @(posedge clk); #1;
    e0 = cyc;
    start = 1'b0;
  endtask

  task automatic run_check(input string tag, input bit noisy);
    int mism = 0;
    last_d = -1;
    for (int c = 0; c < 11*MSG_LEN + 20; c++) begin
      @(posedge clk); #1;
      if (done) begin
        last_d = cyc - e0 + 1;
        break;
      end
      if (noisy) start = 1'b1;
    end
    start = 1'b0;
    chk($sformatf("%s_done_seen", tag), int'(done), 1);
    repeat (3) @(posedge clk);
    #1;
    last_n = wa_q.size() - wbase;
    chk($sformatf("%s_nwrites", tag), last_n, exp_d.size());
    for (int k = 0; k < last_n && k < exp_d.size(); k++) begin
      chk($sformatf("%s_addr%0d", tag, k), wa_q[wbase+k], k);
      chk($sformatf("%s_data%0d", tag, k), wd_q[wbase+k], int'(exp_d[k]));
      chk($sformatf("%s_cyc%0d", tag, k), wc_q[wbase+k] - e0, 11*k + 11);
    end
    chk($sformatf("%s_done_cycle", tag), last_d, 11*exp_d.size() + 1);
    chk($sformatf("%s_done_held", tag), int'(done), 1);
    chk($sformatf("%s_key_valid", tag), int'(key_valid), int'(exp_kv));
    for (int n = 0; n < 256; n++) if (smem[n] !== m_s[n]) mism++;
    chk($sformatf("%s_s_final", tag), mism, 0);
  endtask

  task automatic set_identity();
    for (int n = 0; n < 256; n++) s_init[n] = 8'(n);
  endtask

  task automatic rand_perm();
    logic [7:0] tmp;
    int r;
    set_identity();
    for (int n = 255; n > 0; n--) begin
      r = $urandom_range(n, 0);
      tmp = s_init[n]; s_init[n] = s_init[r]; s_init[r] = tmp;
    end
  endtask

  task automatic put_val(input int pos, input int v);
    for (int n = 0; n < 256; n++) begin
      if (s_init[n] == 8'(v)) begin
        s_init[n]   = s_init[pos];
        s_init[pos] = 8'(v);
      end
    end
  endtask

  task automatic rand_plain();
    for (int k = 0; k < MSG_LEN; k++)
      plain_b[k] = ($urandom_range(26, 0) == 0) ? 8'd32 : 8'(97 + $urandom_range(25, 0));
  endtask

  task automatic ksa(input logic [23:0] key);
    logic [7:0] kb [3];
    logic [7:0] tmp;
    int j = 0;
    kb[0] = key[23:16]; kb[1] = key[15:8]; kb[2] = key[7:0];
    set_identity();
    for (int i = 0; i < 256; i++) begin
      j = (j + int'(s_init[i]) + int'(kb[i % 3])) % 256;
      tmp = s_init[i]; s_init[i] = s_init[j]; s_init[j] = tmp;
    end
  endtask

  initial begin
    string phrase;
    int nw;
    phrase = "the quick brown fox jumps over t";
    reset_n = 1'b0;
    start = 1'b0;
    load_s = 1'b0;
    encrypted_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs_zero", $countones(outs), 0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_not_busy", int'(busy), 0);

    // 1: identity S, zero ciphertext -> first keystream byte 0x02 is rejected
    set_identity();
    for (int k = 0; k < MSG_LEN; k++) plain_b[k] = 8'd0;
    load_mem();
    for (int k = 0; k < MSG_LEN; k++) begin
      enc_b[k] = 8'd0;
      encrypted_data[k*8 +: 8] = 8'd0;
    end
    model_run();
    do_start();
    chk("t1_busy_after_start", int'(busy), 1);
    run_check("t1", 1'b0);
    chk("t1_one_write", last_n, 1);
    chk("t1_byte0_is_02", wd_q[wbase], 2);
    chk("t1_done_at_12", last_d, 12);

    // 2: identity S, plaintext "ab" then all 'a' -> full run
    set_identity();
    load_mem();
    for (int k = 0; k < MSG_LEN; k++) plain_b[k] = 8'h61;
    plain_b[1] = 8'h62;
    make_enc();
    chk("t2_enc0", int'(enc_b[0]), 8'h63);
    chk("t2_enc1", int'(enc_b[1]), 8'h67);
    model_run();
    do_start();
    run_check("t2", 1'b0);
    chk("t2_done_at_353", last_d, 353);
    chk("t2_key_valid_one", int'(key_valid), 1);

    // 3: KSA S with key 0x000249, printable phrase then one '{' byte
    ksa(24'h000249);
    load_mem();
    for (int k = 0; k < MSG_LEN; k++) plain_b[k] = 8'(phrase[k]);
    make_enc();
    model_run();
    do_start();
    run_check("t3a", 1'b0);
    chk("t3a_key_valid_one", int'(key_valid), 1);
    load_mem();
    plain_b[13] = 8'h7B;
    make_enc();
    model_run();
    do_start();
    run_check("t3b", 1'b0);
    chk("t3b_abort_at_13", last_n, 14);
    chk("t3b_key_valid_zero", int'(key_valid), 0);

    // 4: reset mid byte 10, then a clean rerun from the reloaded S
    load_mem();
    rand_plain();
    make_enc();
    do_start();
    for (int c = 0; c < 200 && (cyc - e0) < 115; c++) @(posedge clk);
    #6 reset_n = 1'b0;
    #1 chk("t4_reset_outputs_zero", $countones(outs), 0);
    nw = wa_q.size();
    chk("t4_writes_before_reset", nw - wbase, 10);
    repeat (3) @(posedge clk);
    #1 chk("t4_no_writes_in_reset", wa_q.size(), nw);
    @(negedge clk) reset_n = 1'b1;
    load_mem();
    model_run();
    do_start();
    run_check("t4", 1'b0);

    // 5: start held through every busy state, then a restart from DONE
    rand_perm();
    load_mem();
    rand_plain();
    make_enc();
    model_run();
    do_start();
    run_check("t5", 1'b1);
    rand_plain();
    make_enc();
    model_run();
    do_start();
    chk("t5b_done_dropped", int'(done), 0);
    chk("t5b_busy_again", int'(busy), 1);
    run_check("t5b", 1'b0);

    // 6: i==j on byte 0 and j wrapping past 255 on byte 1
    rand_perm();
    put_val(1, 1);
    put_val(2, 255);
    load_mem();
    rand_plain();
    make_enc();
    model_run();
    do_start();
    run_check("t6", 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
